db15_serial_pad: RTL and testbench

DB15_SERIAL_PAD -- requirements
Module: db15_serial_pad

---
 rtl/db15_pkg.sv | 16 +
 rtl/db15_tick_gen.sv | 29 ++
 rtl/db15_serial_pad.sv | 182 ++++++++++++++++++
 tb/tb_db15_serial_pad.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/db15_pkg.sv
// rtl/db15_pkg.sv - shared constants and FSM state type for the DB15 serial pad reader
package db15_pkg;

  localparam int BITS_PER_PAD = 12;
  localparam int NUM_PADS     = 2;
  localparam int FRAME_BITS   = 24;
  localparam int LOAD_HALVES  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } db15_state_e;

endpackage

// File: rtl/db15_tick_gen.sv
// rtl/db15_tick_gen.sv - free-running divider producing one tick per serial half-period
module db15_tick_gen #(
  parameter int CLK_DIV = 24
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(CLK_DIV - 1));
  assign tick   = w_wrap;

  // Count 0..CLK_DIV-1 and wrap; the last count is the tick cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/db15_serial_pad.sv
// rtl/db15_serial_pad.sv - DB15 two-pad serial reader; optional DB15_DEBOUNCE_EN for two-frame agreement
module db15_serial_pad
  import db15_pkg::*;
#(
  parameter int CLK_DIV    = 24,
  parameter int GAP_HALVES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        JOY_DATA,
  output logic        JOY_CLK,
  output logic        JOY_LOAD,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        frame_done
);

  localparam int HCW = $clog2(GAP_HALVES + LOAD_HALVES + 1);

  db15_state_e     r_state, w_state_nxt;
  logic [HCW-1:0]  r_half, w_half_nxt;
  logic [4:0]      r_bit, w_bit_nxt;
  logic [11:0]     r_cap1, r_cap2, w_cap1_nxt, w_cap2_nxt;
  logic            r_joy_clk, r_joy_load, w_clk_nxt, w_load_nxt;
  logic [11:0]     r_joy1, r_joy2;
  logic            r_frame_done;
  logic [1:0]      r_sync;
  logic            w_tick, w_done, w_stable;
  logic [3:0]      w_idx2;

  db15_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (w_tick)
  );

  // Second-pad bit index; the 4-bit subtraction wraps 12..23 onto 0..11.
  assign w_idx2 = r_bit[3:0] - 4'd12;

  // Two-flop synchronizer for the asynchronous pad data line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], JOY_DATA};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and pad-line logic; pad lines only move on a tick.
  always_comb begin
    w_state_nxt = r_state;
    w_half_nxt  = r_half;
    w_bit_nxt   = r_bit;
    w_cap1_nxt  = r_cap1;
    w_cap2_nxt  = r_cap2;
    w_clk_nxt   = r_joy_clk;
    w_load_nxt  = r_joy_load;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_tick) begin
          if (r_half == HCW'(GAP_HALVES - 1)) begin
            w_state_nxt = LOAD;
            w_half_nxt  = '0;
            w_load_nxt  = 1'b0;
          end else begin
            w_half_nxt = r_half + 1'b1;
          end
        end
      end
      LOAD: begin
        if (w_tick) begin
          if (r_half == HCW'(LOAD_HALVES - 1)) begin
            w_state_nxt = SHIFT;
            w_half_nxt  = '0;
            w_bit_nxt   = '0;
            w_load_nxt  = 1'b1;
          end else begin
            w_half_nxt = r_half + 1'b1;
          end
        end
      end
      SHIFT: begin
        if (r_bit >= 5'(FRAME_BITS)) begin
          w_state_nxt = DONE;
        end else if (w_tick) begin
          if (r_joy_clk) begin
            w_clk_nxt = 1'b0;
          end else begin
            w_clk_nxt = 1'b1;
            if (r_bit < 5'(BITS_PER_PAD)) begin
              w_cap1_nxt[r_bit[3:0]] = ~r_sync[1];
            end else begin
              w_cap2_nxt[w_idx2] = ~r_sync[1];
            end
            if (r_bit == 5'(FRAME_BITS - 1)) begin
              w_state_nxt = DONE;
            end else begin
              w_bit_nxt = r_bit + 1'b1;
            end
          end
        end
      end
      DONE: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Register the counters, captures and pad lines chosen above.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_half     <= '0;
      r_bit      <= '0;
      r_cap1     <= '0;
      r_cap2     <= '0;
      r_joy_clk  <= 1'b1;
      r_joy_load <= 1'b1;
    end else begin
      r_half     <= w_half_nxt;
      r_bit      <= w_bit_nxt;
      r_cap1     <= w_cap1_nxt;
      r_cap2     <= w_cap2_nxt;
      r_joy_clk  <= w_clk_nxt;
      r_joy_load <= w_load_nxt;
    end
  end

`ifdef DB15_DEBOUNCE_EN
  logic [11:0] r_prev1, r_prev2;

  assign w_stable = (r_cap1 == r_prev1) && (r_cap2 == r_prev2);

  // Remember each completed frame so the next one can be compared with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev1 <= '0;
      r_prev2 <= '0;
    end else if (w_done) begin
      r_prev1 <= r_cap1;
      r_prev2 <= r_cap2;
    end
  end
`else
  assign w_stable = 1'b1;
`endif

  // Publish whole frames only, and pulse frame_done once per frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_joy1       <= '0;
      r_joy2       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_done;
      if (w_done && w_stable) begin
        r_joy1 <= r_cap1;
        r_joy2 <= r_cap2;
      end
    end
  end

  assign JOY_CLK    = r_joy_clk;
  assign JOY_LOAD   = r_joy_load;
  assign joystick1  = {4'b0000, r_joy1};
  assign joystick2  = {4'b0000, r_joy2};
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_db15_serial_pad.sv
// tb/tb_db15_serial_pad.sv - self-checking bench with a shift-register pad model and frame-level reference
module tb_db15_serial_pad;

  localparam int CLK_DIV = 24;
  localparam int FRAME_CYCLES = (2 + 2 + 48) * CLK_DIV;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        JOY_DATA = 1'b1;
  logic        JOY_CLK, JOY_LOAD, frame_done;
  logic [15:0] joystick1, joystick2;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  db15_serial_pad #(.CLK_DIV(CLK_DIV), .GAP_HALVES(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .JOY_DATA   (JOY_DATA),
    .JOY_CLK    (JOY_CLK),
    .JOY_LOAD   (JOY_LOAD),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pad model: a 24-bit parallel-in shift register, loaded while JOY_LOAD is low,
  // advancing one bit on every JOY_CLK rising edge; buttons are active-low.
  logic [23:0] pat_next = 24'hFFFFFF;
  logic [23:0] pat_cur = 24'hFFFFFF;
  int          pad_idx = 0;
  logic        pad_prev_clk = 1'b1;
  always @(negedge clk) begin
    if (!JOY_LOAD) begin
      pat_cur = pat_next;
      pad_idx = 0;
    end else if (JOY_CLK && !pad_prev_clk && pad_idx < 24) begin
      pad_idx++;
    end
    pad_prev_clk = JOY_CLK;
    JOY_DATA = (pad_idx < 24) ? pat_cur[pad_idx] : 1'b1;
  end

  // Line monitor: per-frame statistics, snapshotted when frame_done is seen.
  int   st_load_w = 0, st_pulses = 0, st_badw = 0, st_inload = 0, st_glitch = 0;
  int   f_load_w = 0, f_pulses = 0, f_badw = 0, f_inload = 0, f_glitch = 0;
  int   load_run = 0, clk_run = 0;
  logic mon_load = 1'b1, mon_clk = 1'b1;
  logic [15:0] mon_j1 = '0, mon_j2 = '0;
  always @(negedge clk) begin
    if (!reset_n) begin
      st_load_w = 0; st_pulses = 0; st_badw = 0; st_inload = 0; st_glitch = 0;
      load_run = 0; clk_run = 0;
    end else begin
      if (!JOY_LOAD) load_run++;
      if (!mon_load && JOY_LOAD) begin
        st_load_w = load_run;
        load_run = 0;
      end
      if (!JOY_CLK) clk_run++;
      if (!mon_clk && JOY_CLK) begin
        st_pulses++;
        if (clk_run != CLK_DIV) st_badw++;
        clk_run = 0;
      end
      if ((JOY_CLK != mon_clk) && (!JOY_LOAD || !mon_load)) st_inload++;
      if (!frame_done && (joystick1 != mon_j1 || joystick2 != mon_j2)) st_glitch++;
      if (frame_done) begin
        f_load_w = st_load_w; f_pulses = st_pulses; f_badw = st_badw;
        f_inload = st_inload; f_glitch = st_glitch;
        st_load_w = 0; st_pulses = 0; st_badw = 0; st_inload = 0; st_glitch = 0;
      end
    end
    mon_load = JOY_LOAD;
    mon_clk = JOY_CLK;
    mon_j1 = joystick1;
    mon_j2 = joystick2;
  end

  // Reference model: buttons seen by the host after each complete frame.
  logic [15:0] m_j1 = '0, m_j2 = '0;
  logic [23:0] m_prev = 24'hFFFFFF;
  int          rel_cyc = 0;
  int          last_done = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    n_checks++;
    assert (obs >= lo && obs <= hi) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_jclk"}, 32'(JOY_CLK), 32'd1);
    check({tag, "_jload"}, 32'(JOY_LOAD), 32'd1);
    check({tag, "_joy1"}, 32'(joystick1), 32'd0);
    check({tag, "_joy2"}, 32'(joystick2), 32'd0);
    check({tag, "_fdone"}, 32'(frame_done), 32'd0);
  endtask

  task automatic model_frame(input logic [23:0] p);
`ifdef DB15_DEBOUNCE_EN
    if (p == m_prev) begin
      m_j1 = {4'b0000, ~p[11:0]};
      m_j2 = {4'b0000, ~p[23:12]};
    end
    m_prev = p;
`else
    m_j1 = {4'b0000, ~p[11:0]};
    m_j2 = {4'b0000, ~p[23:12]};
`endif
  endtask

  task automatic run_frame(input string tag, input logic [23:0] p, input bit first);
    int at;
    int n;
    pat_next = p;
    at = -1;
    n = 0;
    while (at < 0 && n < 3 * FRAME_CYCLES) begin
      @(negedge clk);
      n++;
      if (frame_done) at = cyc;
    end
    #2;
    check({tag, "_seen"}, 32'(at >= 0), 32'd1);
    model_frame(p);
    if (first) check_range({tag, "_after_release"}, at - rel_cyc, FRAME_CYCLES - 3, FRAME_CYCLES + 3);
    else       check({tag, "_period"}, 32'(at - last_done), 32'(FRAME_CYCLES));
    last_done = at;
    check({tag, "_joy1"}, 32'(joystick1), 32'(m_j1));
    check({tag, "_joy2"}, 32'(joystick2), 32'(m_j2));
    check({tag, "_load_w"}, 32'(f_load_w), 32'(2 * CLK_DIV));
    check({tag, "_pulses"}, 32'(f_pulses), 32'd24);
    check({tag, "_pulse_w"}, 32'(f_badw), 32'd0);
    check({tag, "_clk_in_load"}, 32'(f_inload), 32'd0);
    check({tag, "_partial"}, 32'(f_glitch), 32'd0);
    @(negedge clk);
    check({tag, "_pulse_len"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    int n, rises;
    logic pc;

    pat_next = 24'hFFFFFE;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    rel_cyc = cyc;

    run_frame("bit0", 24'hFFFFFE, 1'b1);
    run_frame("bit12_23", ~(24'h1 << 12 | 24'h1 << 23), 1'b0);
    run_frame("alt_a", {12'hFFF, ~12'h001}, 1'b0);
    run_frame("alt_b", {12'hFFF, ~12'h002}, 1'b0);
    run_frame("hold_a", {12'hFFF, ~12'h004}, 1'b0);
    run_frame("hold_b", {12'hFFF, ~12'h004}, 1'b0);
    for (int k = 0; k < 3; k++) begin
      r = $urandom;
      run_frame("rand_a", r[23:0], 1'b0);
      run_frame("rand_b", r[23:0], 1'b0);
    end

    // Reset in the middle of bit 10 of a frame.
    n = 0;
    while (JOY_LOAD && n < 3 * FRAME_CYCLES) begin @(negedge clk); n++; end
    while (!JOY_LOAD && n < 3 * FRAME_CYCLES) begin @(negedge clk); n++; end
    rises = 0;
    pc = JOY_CLK;
    while (rises < 10 && n < 3 * FRAME_CYCLES) begin
      @(negedge clk);
      n++;
      if (JOY_CLK && !pc) rises++;
      pc = JOY_CLK;
    end
    check("reach_bit10", 32'(rises), 32'd10);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("midreset");
    m_j1 = '0;
    m_j2 = '0;
    m_prev = 24'hFFFFFF;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rel_cyc = cyc;
    r = $urandom;
    run_frame("post_reset", r[23:0], 1'b1);
    run_frame("post_reset2", r[23:0], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
